// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: major opcodes understood by the main decoder and
// the program-loader state encoding.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } loader_state_t;

endpackage

// File: rtl/opcode_check.sv
// Combinational opcode filter: flags whether a 7-bit major opcode belongs to
// the set the main decoder implements.
module opcode_check
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       legal
);

    // Membership test against the supported opcode set.
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE, OP_RTYPE,
            OP_BRANCH, OP_ITYPE, OP_JAL: legal = 1'b1;
            default:                     legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader. Receives a 16-bit little-endian word count and
// that many little-endian 32-bit instructions, writes each legal word into
// instruction memory and keeps the core in reset until the load completes.
//
// Handshake: a byte moves on a rising edge where byte_valid_i && byte_ready_o.
// byte_ready_o is registered from the state only (high in HDR0/HDR1/DATA), so
// the source must hold byte_valid_i/byte_data_i stable until it sees ready.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_count_o,
    output loader_state_t     state_o
);

    // Largest word count that fits in memory without wrapping the address.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    loader_state_t state;
    logic [15:0]   count;
    logic [1:0]    byte_idx;
    logic [23:0]   shift;
    logic          accept;
    logic [15:0]   hdr_n;
    logic [31:0]   assembled;
    logic          opcode_legal;
    logic          last_word;

    assign accept    = byte_valid_i && byte_ready_o;
    // Full header value as it completes on the HDR1 accept.
    assign hdr_n     = {byte_data_i, count[7:0]};
    // Word as it completes on the 4th byte: earlier bytes sit low in shift.
    assign assembled = {byte_data_i, shift};
    assign last_word = (32'(word_count_o) + 32'd1) == 32'(count);
    assign state_o   = state;

    opcode_check u_opcode_check (
        .opcode (assembled[6:0]),
        .legal  (opcode_legal)
    );

    // Loader FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_IDLE;
            count        <= '0;
            byte_idx     <= '0;
            shift        <= '0;
            byte_ready_o <= 1'b0;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            imem_wdata_o <= '0;
            cpu_rst_n_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            word_count_o <= '0;
        end else begin
            imem_we_o <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_i) begin
                        state        <= ST_HDR0;
                        count        <= '0;
                        byte_idx     <= '0;
                        imem_addr_o  <= '0;
                        word_count_o <= '0;
                        done_o       <= 1'b0;
                        err_o        <= 1'b0;
                        cpu_rst_n_o  <= 1'b0;
                        busy_o       <= 1'b1;
                        byte_ready_o <= 1'b1;
                    end
                end
                ST_HDR0: begin
                    if (accept) begin
                        count[7:0] <= byte_data_i;
                        state      <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (accept) begin
                        count[15:8] <= byte_data_i;
                        if (hdr_n == 16'd0) begin
                            state        <= ST_DONE;
                            byte_ready_o <= 1'b0;
                            busy_o       <= 1'b0;
                            done_o       <= 1'b1;
                            cpu_rst_n_o  <= 1'b1;
                        end else if ({1'b0, hdr_n} > MAX_WORDS) begin
                            state        <= ST_ERROR;
                            byte_ready_o <= 1'b0;
                            busy_o       <= 1'b0;
                            err_o        <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        shift    <= {byte_data_i, shift[23:8]};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            byte_ready_o <= 1'b0;
                            if (opcode_legal) begin
                                state        <= ST_WRITE;
                                imem_we_o    <= 1'b1;
                                imem_addr_o  <= word_count_o[ADDR_W-1:0];
                                imem_wdata_o <= assembled;
                            end else begin
                                state  <= ST_ERROR;
                                busy_o <= 1'b0;
                                err_o  <= 1'b1;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    word_count_o <= word_count_o + 1'b1;
                    if (last_word) begin
                        state       <= ST_DONE;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        cpu_rst_n_o <= 1'b1;
                    end else begin
                        state        <= ST_DATA;
                        byte_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    byte_ready_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule
